motor_drive_ctrl: RTL

- Parametrised successor of the motor-command path: selects assistance or throttle command, applies brake and tilt safety interlocks, slew-limits the duty, and generates a glitch-free PWM for the ESC speed input.
- Sits between the assistance algorithm / throttle ADC and the ESC pin.
- Adds behaviour the current path lacks:
  - latched tilt fault with explicit clear;
  - zero-command arming;
  - ramp limiting;
  - period-aligned duty update.

---
 rtl/motor_drive_pkg.sv | 31 +++
 rtl/pwm_gen.sv | 53 +++++
 rtl/motor_drive_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/motor_drive_pkg.sv
// Shared types, defaults and helpers for the motor drive command path.
package motor_drive_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam int DEF_W          = 12;
    localparam int DEF_ANG_W      = 12;
    localparam int DEF_TILT_LIMIT = 512;
    localparam int DEF_RAMP_DIV   = 50000;
    localparam int DEF_RAMP_STEP  = 16;
    localparam int DEF_PWM_DIV    = 1;

    // Magnitude of an ang_w-bit signed angle (already sign-extended); the
    // most-negative code clamps to the largest positive magnitude.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] v,
                                            input int unsigned ang_w);
        logic [31:0] mag;
        logic [31:0] max_mag;
        max_mag = (32'd1 << (ang_w - 1)) - 32'd1;
        mag     = v[31] ? 32'(-v) : 32'(v);
        if (mag > max_mag) begin
            mag = max_mag;
        end
        return mag;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Period-aligned PWM generator: prescaled counter, shadow duty loaded at
// each period boundary, and an immediate kill input.
module pwm_gen #(
    parameter int W   = 12,
    parameter int DIV = 1
) (
    input  logic         c50m,
    input  logic         rst_n,
    input  logic [W-1:0] duty_in,
    input  logic         force_zero,
    output logic         pwm_out
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic          pwm_q, pwm_d;
    logic          adv;
    logic          wrap;

    always_comb begin
        adv   = (pre_q == PW'(DIV - 1));
        pre_d = adv ? '0 : pre_q + PW'(1);
        cnt_d = adv ? cnt_q + W'(1) : cnt_q;
        wrap  = adv && (cnt_q == '1);

        shadow_d = wrap ? duty_in : shadow_q;
        pwm_d    = (cnt_q < shadow_q);
        // A safety kill must not wait for the period boundary.
        if (force_zero) begin
            shadow_d = '0;
            pwm_d    = 1'b0;
        end
    end

    always_ff @(posedge c50m or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Motor command path: demand select, tilt/brake interlocks, slew-limited
// duty and glitch-free PWM towards the ESC speed input.
import motor_drive_pkg::*;

module motor_drive_ctrl #(
    parameter int W          = DEF_W,
    parameter int ANG_W      = DEF_ANG_W,
    parameter int TILT_LIMIT = DEF_TILT_LIMIT,
    parameter int RAMP_DIV   = DEF_RAMP_DIV,
    parameter int RAMP_STEP  = DEF_RAMP_STEP,
    parameter int PWM_DIV    = DEF_PWM_DIV
) (
    input  logic             c50m,
    input  logic             rst_n,
    input  logic [W-1:0]     assist_cmd,
    input  logic [W-1:0]     throttle_cmd,
    input  logic             mode_sel,
    input  logic             brake,
    input  logic [ANG_W-1:0] roll,
    input  logic [ANG_W-1:0] pitch,
    input  logic             fault_clr,
    output logic             pwm_out,
    output logic [W-1:0]     duty,
    output logic [1:0]       state,
    output logic             fault
);
    localparam int          RC_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [31:0] TILT_LIM = 32'(TILT_LIMIT);
    localparam logic [W:0]  STEP_EXT = (W + 1)'(RAMP_STEP);

    state_e          state_q, state_d;
    logic [W-1:0]    target_q, target_d;
    logic [W-1:0]    duty_q, duty_d;
    logic [RC_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic            ramp_tick;
    logic            tilt_bad;
    logic            force_zero;
    logic [W:0]      step_sum;

    always_comb begin
        target_d   = mode_sel ? assist_cmd : throttle_cmd;
        ramp_tick  = (ramp_cnt_q == RC_W'(RAMP_DIV - 1));
        ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + RC_W'(1);
        tilt_bad   = (abs_sat(32'(signed'(roll)), ANG_W) > TILT_LIM) ||
                     (abs_sat(32'(signed'(pitch)), ANG_W) > TILT_LIM);
    end

    // Tilt outranks brake; arming from IDLE requires a zero demand.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        step_sum = {1'b0, duty_q} + STEP_EXT;
        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (tilt_bad) begin
                    state_d = FAULT;
                end else if (!brake && (target_q == '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tilt_bad) begin
                    state_d = FAULT;
                    duty_d  = '0;
                end else if (brake) begin
                    state_d = IDLE;
                    duty_d  = '0;
                end else if (target_q < duty_q) begin
                    duty_d = target_q;
                end else if (ramp_tick && (target_q > duty_q)) begin
                    duty_d = (step_sum > {1'b0, target_q}) ? target_q : step_sum[W-1:0];
                end
            end
            FAULT: begin
                duty_d = '0;
                if (fault_clr && !tilt_bad) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                duty_d  = '0;
            end
        endcase
    end

    always_ff @(posedge c50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            duty_q     <= '0;
            ramp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            duty_q     <= duty_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    assign force_zero = (state_d != RUN);

    pwm_gen #(
        .W   (W),
        .DIV (PWM_DIV)
    ) u_pwm (
        .c50m       (c50m),
        .rst_n      (rst_n),
        .duty_in    (duty_q),
        .force_zero (force_zero),
        .pwm_out    (pwm_out)
    );

    assign duty  = duty_q;
    assign state = state_q;
    assign fault = (state_q == FAULT);

endmodule
